// File: rtl/eth_vlg_phy_tx.sv
// Byte-wide Ethernet MAC transmitter: preamble, SFD, header, payload,
// zero pad and reflected CRC-32 FCS, followed by the inter-frame gap.
module eth_vlg_phy_tx #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_LEN      = 1500,
    parameter int IFG          = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        req,
    output logic        ack,
    output logic        done,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] ethertype,
    input  logic [15:0] length,
    input  logic [7:0]  dat_in,
    input  logic        abort,
    output logic        phy_clk,
    output logic        phy_rst,
    output logic [7:0]  phy_dat,
    output logic        phy_val,
    output logic        phy_err
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, GAP
    } state_t;

    localparam logic [15:0] MAXL = 16'(MAX_LEN);
    localparam logic [15:0] MINP = 16'(MIN_PAYLOAD);
    localparam logic [15:0] PREL = 16'(PREAMBLE_LEN);
    localparam logic [15:0] GAPL = 16'(IFG - 1);

    state_t       st;
    logic [15:0]  cnt;
    logic [15:0]  len_q;
    logic [15:0]  plen_q;
    logic [15:0]  req_left;
    logic         req_q;
    logic [31:0]  crc;
    logic [111:0] hdr_q;

    logic [15:0]  len_eff;
    logic [15:0]  plen_in;
    logic [15:0]  nidx;
    logic         n_pay;
    logic         n_pad;
    logic [7:0]   nbyte;
    logic [7:0]   hbyte;

    function automatic logic [31:0] crc8(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign phy_clk = clk;
    assign phy_rst = ~rst;
    assign req     = req_q & ~abort;

    assign len_eff = (length > MAXL) ? MAXL : length;
    assign plen_in = (len_eff < MINP) ? MINP : len_eff;
    assign hbyte   = hdr_q[111:104];

    // index of the byte after the current one within payload+pad
    always_comb begin
        nidx  = (st == HEADER) ? 16'd0 : cnt + 16'd1;
        n_pay = nidx < len_q;
        n_pad = !n_pay && (nidx < plen_q);
        nbyte = n_pay ? dat_in : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= IDLE;
            cnt      <= '0;
            len_q    <= '0;
            plen_q   <= '0;
            req_left <= '0;
            req_q    <= 1'b0;
            crc      <= '1;
            hdr_q    <= '0;
            ack      <= 1'b0;
            done     <= 1'b0;
            phy_dat  <= '0;
            phy_val  <= 1'b0;
            phy_err  <= 1'b0;
        end else begin
            ack     <= 1'b0;
            done    <= 1'b0;
            phy_err <= 1'b0;
            if (req_q) begin
                req_left <= req_left - 16'd1;
                if (req_left == 16'd1)
                    req_q <= 1'b0;
            end
            if (abort && st != IDLE && st != GAP) begin
                st      <= GAP;
                cnt     <= '0;
                req_q   <= 1'b0;
                phy_val <= 1'b1;
                phy_err <= 1'b1;
                phy_dat <= 8'h00;
            end else begin
                case (st)
                    IDLE: begin
                        phy_val <= 1'b0;
                        phy_dat <= 8'h00;
                        if (rdy) begin
                            hdr_q   <= {dst_mac, src_mac, ethertype};
                            len_q   <= len_eff;
                            plen_q  <= plen_in;
                            crc     <= '1;
                            ack     <= 1'b1;
                            phy_val <= 1'b1;
                            phy_dat <= 8'h55;
                            cnt     <= 16'd1;
                            st      <= PREAMBLE;
                        end
                    end
                    PREAMBLE: begin
                        if (cnt == PREL) begin
                            phy_dat <= 8'hD5;
                            st      <= SFD;
                        end else begin
                            phy_dat <= 8'h55;
                            cnt     <= cnt + 16'd1;
                        end
                    end
                    SFD: begin
                        phy_dat <= hbyte;
                        hdr_q   <= hdr_q << 8;
                        crc     <= crc8(crc, hbyte);
                        cnt     <= '0;
                        st      <= HEADER;
                    end
                    HEADER, PAYLOAD, PAD: begin
                        // first request two bytes ahead of the payload
                        if (st == HEADER && cnt == 16'd11 && len_q != 16'd0) begin
                            req_q    <= 1'b1;
                            req_left <= len_q;
                        end
                        if (st == HEADER && cnt != 16'd13) begin
                            phy_dat <= hbyte;
                            hdr_q   <= hdr_q << 8;
                            crc     <= crc8(crc, hbyte);
                            cnt     <= cnt + 16'd1;
                        end else if (n_pay || n_pad) begin
                            phy_dat <= nbyte;
                            crc     <= crc8(crc, nbyte);
                            cnt     <= nidx;
                            st      <= n_pay ? PAYLOAD : PAD;
                        end else begin
                            phy_dat <= ~crc[7:0];
                            crc     <= {8'h00, crc[31:8]};
                            cnt     <= '0;
                            st      <= FCS;
                        end
                    end
                    FCS: begin
                        if (cnt == 16'd3) begin
                            phy_val <= 1'b0;
                            phy_dat <= 8'h00;
                            cnt     <= '0;
                            st      <= GAP;
                        end else begin
                            phy_dat <= ~crc[7:0];
                            crc     <= {8'h00, crc[31:8]};
                            cnt     <= cnt + 16'd1;
                            done    <= (cnt == 16'd2);
                        end
                    end
                    GAP: begin
                        phy_val <= 1'b0;
                        phy_dat <= 8'h00;
                        if (cnt == GAPL) begin
                            cnt <= '0;
                            st  <= IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_vlg_phy_tx.sv
// Directed testbench for eth_vlg_phy_tx: frame layout, FCS residue,
// request timing, back-to-back gap, abort and mid-frame reset.
module tb_eth_vlg_phy_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        abort = 1'b0;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = '0;
    logic [15:0] ethertype = '0;
    logic [15:0] length = '0;
    logic [7:0]  dat_in = '0;
    logic        req, ack, done;
    logic        phy_clk, phy_rst, phy_val, phy_err;
    logic [7:0]  phy_dat;

    eth_vlg_phy_tx dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req(req), .ack(ack),
        .done(done), .dst_mac(dst_mac), .src_mac(src_mac),
        .ethertype(ethertype), .length(length), .dat_in(dat_in),
        .abort(abort), .phy_clk(phy_clk), .phy_rst(phy_rst),
        .phy_dat(phy_dat), .phy_val(phy_val), .phy_err(phy_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] hdr_exp [14] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
        8'h08, 8'h06
    };
    int vcnt, first_val, ack_cyc, ack_cnt, done_cyc, done_cnt;
    int req_cnt, req_first, req_last, err_cnt, err_cyc, bad_err;
    int rst_bad;

    function automatic logic [31:0] residue();
        logic [31:0] c;
        logic [31:0] r;
        c = '1;
        for (int i = 8; i < q.size(); i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        for (int b = 0; b < 32; b++)
            r[b] = c[31 - b];
        return r;
    endfunction

    // call right after a falling edge; rdy is sampled at the next rising edge
    task automatic send_frame(input logic [15:0] len, input int maxcyc,
                              input int abort_at, input int rst_at);
        int idx;
        logic prev_req;
        q.delete();
        vcnt = 0; first_val = -1; ack_cyc = -1; ack_cnt = 0;
        done_cyc = -1; done_cnt = 0; req_cnt = 0; req_first = -1;
        req_last = -1; err_cnt = 0; err_cyc = -1; bad_err = 0;
        rst_bad = 0;
        dst_mac = 48'hFFFFFFFFFFFF;
        src_mac = 48'h001122334455;
        ethertype = 16'h0806;
        length = len;
        rdy = 1'b1;
        idx = 0;
        prev_req = 1'b0;
        for (int c = 1; c <= maxcyc; c++) begin
            @(negedge clk);
            rdy = 1'b0;
            abort = 1'b0;
            if (c == rst_at + 1) rst = 1'b1;
            if (c == abort_at) begin
                abort = 1'b1;
                #1;
            end
            if (c == rst_at) begin
                rst = 1'b0;
                #1;
                if ({req, ack, done, phy_val, phy_err, phy_dat} !== 13'h0
                    || phy_rst !== 1'b1)
                    rst_bad++;
            end
            if (phy_val === 1'b1) begin
                q.push_back(phy_dat);
                vcnt++;
                if (first_val < 0) first_val = c;
            end
            if (ack === 1'b1) begin ack_cnt++; ack_cyc = c; end
            if (done === 1'b1) begin done_cnt++; done_cyc = c; end
            if (req === 1'b1) begin
                req_cnt++;
                if (req_first < 0) req_first = c;
                req_last = c;
            end
            if (phy_err === 1'b1) begin
                err_cnt++;
                err_cyc = c;
                if (phy_val !== 1'b1 || phy_dat !== 8'h00) bad_err++;
            end
            if (prev_req) begin
                dat_in = idx[7:0];
                idx++;
            end
            prev_req = req;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({req, ack, done, phy_val, phy_err, phy_dat} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {req, ack, done, phy_val, phy_err, phy_dat});
        end
        checks++;
        if (phy_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_phy_rst got=%b want=1", phy_rst);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (phy_rst !== 1'b0 || phy_val !== 1'b0) begin
            failures++;
            $display("FAIL release_state phy_rst=%b phy_val=%b want 0 0",
                     phy_rst, phy_val);
        end
    endtask

    task automatic test_min_frame();
        int bad_pre, bad_hdr, bad_pad;
        send_frame(16'd0, 85, -1, -1);
        bad_pre = 0; bad_hdr = 0; bad_pad = 0;
        checks++;
        if (vcnt !== 72) begin
            failures++;
            $display("FAIL min_len got=%0d want=72", vcnt);
        end
        checks++;
        if (first_val !== 1 || ack_cyc !== 1 || ack_cnt !== 1) begin
            failures++;
            $display("FAIL min_start val=%0d ack=%0d n=%0d want 1 1 1",
                     first_val, ack_cyc, ack_cnt);
        end
        if (q.size() >= 72) begin
            for (int i = 0; i < 7; i++)
                if (q[i] !== 8'h55) bad_pre++;
            if (q[7] !== 8'hD5) bad_pre++;
            for (int i = 0; i < 14; i++)
                if (q[8 + i] !== hdr_exp[i]) bad_hdr++;
            for (int i = 22; i < 68; i++)
                if (q[i] !== 8'h00) bad_pad++;
        end else begin
            bad_pre = 1; bad_hdr = 1; bad_pad = 1;
        end
        checks++;
        if (bad_pre !== 0) begin
            failures++;
            $display("FAIL min_preamble bad=%0d want=0", bad_pre);
        end
        checks++;
        if (bad_hdr !== 0) begin
            failures++;
            $display("FAIL min_header bad=%0d want=0", bad_hdr);
        end
        checks++;
        if (bad_pad !== 0) begin
            failures++;
            $display("FAIL min_pad bad=%0d want=0", bad_pad);
        end
        checks++;
        if (residue() !== 32'hC704DD7B) begin
            failures++;
            $display("FAIL min_fcs got=%h want=c704dd7b", residue());
        end
        checks++;
        if (done_cyc !== 72 || done_cnt !== 1 || req_cnt !== 0 || err_cnt !== 0) begin
            failures++;
            $display("FAIL min_ctrl done=%0d/%0d req=%0d err=%0d want 72/1 0 0",
                     done_cyc, done_cnt, req_cnt, err_cnt);
        end
    endtask

    task automatic test_payload_100();
        int bad;
        send_frame(16'd100, 139, -1, -1);
        bad = 0;
        checks++;
        if (req_cnt !== 100 || req_first !== 21 || req_last !== 120) begin
            failures++;
            $display("FAIL p100_req n=%0d first=%0d last=%0d want 100 21 120",
                     req_cnt, req_first, req_last);
        end
        if (q.size() >= 122) begin
            for (int i = 0; i < 100; i++)
                if (q[22 + i] !== 8'(i)) bad++;
        end else bad = 1;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL p100_data bad=%0d want=0", bad);
        end
        checks++;
        if (vcnt !== 126 || done_cyc !== 126) begin
            failures++;
            $display("FAIL p100_len got=%0d done=%0d want 126 126",
                     vcnt, done_cyc);
        end
        checks++;
        if (residue() !== 32'hC704DD7B) begin
            failures++;
            $display("FAIL p100_fcs got=%h want=c704dd7b", residue());
        end
    endtask

    task automatic test_oversize();
        send_frame(16'd2000, 1539, -1, -1);
        checks++;
        if (req_cnt !== 1500) begin
            failures++;
            $display("FAIL big_req got=%0d want=1500", req_cnt);
        end
        checks++;
        if (vcnt !== 1526 || done_cnt !== 1) begin
            failures++;
            $display("FAIL big_len got=%0d done=%0d want 1526 1",
                     vcnt, done_cnt);
        end
        checks++;
        if (residue() !== 32'hC704DD7B) begin
            failures++;
            $display("FAIL big_fcs got=%h want=c704dd7b", residue());
        end
    endtask

    task automatic test_back_to_back();
        int acks[$];
        int dones[$];
        length = 16'd46;
        rdy = 1'b1;
        for (int c = 1; c <= 170; c++) begin
            @(negedge clk);
            if (c == 150) rdy = 1'b0;
            if (ack === 1'b1) acks.push_back(c);
            if (done === 1'b1) dones.push_back(c);
        end
        checks++;
        if (acks.size() !== 2 || dones.size() !== 2) begin
            failures++;
            $display("FAIL b2b_count acks=%0d dones=%0d want 2 2",
                     acks.size(), dones.size());
        end else begin
            checks++;
            if (dones[0] !== 72 || acks[1] - dones[0] !== 14) begin
                failures++;
                $display("FAIL b2b_gap done=%0d ack2=%0d want 72 86",
                         dones[0], acks[1]);
            end
        end
    endtask

    task automatic test_abort();
        send_frame(16'd100, 43, 30, -1);
        checks++;
        if (err_cnt !== 1 || err_cyc !== 31 || bad_err !== 0) begin
            failures++;
            $display("FAIL abort_err n=%0d cyc=%0d bad=%0d want 1 31 0",
                     err_cnt, err_cyc, bad_err);
        end
        checks++;
        if (req_cnt !== 9 || req_last !== 29) begin
            failures++;
            $display("FAIL abort_req n=%0d last=%0d want 9 29",
                     req_cnt, req_last);
        end
        checks++;
        if (done_cnt !== 0 || vcnt !== 31) begin
            failures++;
            $display("FAIL abort_frame done=%0d val=%0d want 0 31",
                     done_cnt, vcnt);
        end
        send_frame(16'd0, 85, -1, -1);
        checks++;
        if (ack_cyc !== 1 || residue() !== 32'hC704DD7B) begin
            failures++;
            $display("FAIL abort_idle ack=%0d fcs=%h want 1 c704dd7b",
                     ack_cyc, residue());
        end
    endtask

    task automatic test_reset_mid();
        send_frame(16'd100, 16, -1, 15);
        checks++;
        if (rst_bad !== 0 || done_cnt !== 0) begin
            failures++;
            $display("FAIL rst_mid bad=%0d done=%0d want 0 0",
                     rst_bad, done_cnt);
        end
        send_frame(16'd0, 85, -1, -1);
        checks++;
        if (first_val !== 1 || q.size() == 0 || q[0] !== 8'h55) begin
            failures++;
            $display("FAIL rst_restart first=%0d want=1", first_val);
        end
        checks++;
        if (residue() !== 32'hC704DD7B || done_cyc !== 72) begin
            failures++;
            $display("FAIL rst_fcs got=%h done=%0d want c704dd7b 72",
                     residue(), done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_min_frame();
        test_payload_100();
        test_oversize();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
